// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
// Holds the default bus widths, the fetch FSM state type and the counter width rule.
package fetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Counters must hold the value DEPTH itself, hence depth+1 codes.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and a single-cycle clear.
// Serves as both the PC tag queue and the instruction buffer of the fetch unit.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      clr,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: issues word reads at PC, buffers responses with their PC for decode.
// Define FETCH_ALIGN_CHECK_EN to turn misaligned PCs into zero instructions flagged by MISALIGN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] PC,
    input  logic              PC_VALID,
    output logic              PC_READY,
    input  logic              FLUSH,
    output logic              IMEM_REQ,
    output logic [ADDR_W-3:0] IMEM_ADDR,
    input  logic              IMEM_GNT,
    input  logic              IMEM_RVALID,
    input  logic [DATA_W-1:0] IMEM_RDATA,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    output logic [DATA_W-1:0] INSTR,
    output logic [ADDR_W-1:0] INSTR_PC,
    output logic              PROTO_ERR,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              MISALIGN,
`endif
    output fetch_state_t      STATE
);

    // Handshakes: PC transfers when PC_VALID & PC_READY; IMEM request transfers when
    // IMEM_REQ & IMEM_GNT; decode transfers when INSTR_VALID & INSTR_READY. A valid
    // source holds its payload until the transfer; ready never depends on a later cycle.

    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t             state;
    fetch_state_t             state_nxt;
    logic [CNT_W-1:0]         outstanding;
    logic [CNT_W-1:0]         fifo_count;
    logic [CNT_W-1:0]         discard;
    logic [CNT_W-1:0]         discard_nxt;
    logic [CNT_W-1:0]         credit;
    logic                     can_accept;
    logic                     issue;
    logic                     resp_keep;
    logic                     resp_drop;
    logic                     resp_err;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic [ADDR_W+DATA_W-1:0] fifo_wdata;
    logic [ADDR_W+DATA_W-1:0] fifo_rdata;
    logic [ADDR_W-1:0]        tag_pc;

    assign credit     = DEPTH_C - outstanding - fifo_count;
    assign can_accept = PC_VALID && (credit != '0) && !FLUSH && (state != DRAIN);
    assign IMEM_ADDR  = PC[ADDR_W-1:2];
    assign issue      = IMEM_REQ && IMEM_GNT;

    // Responses to fetches killed by a flush are older than any live fetch, so they go first.
    assign resp_drop = IMEM_RVALID && (discard != '0);
    assign resp_keep = IMEM_RVALID && (discard == '0) && (outstanding != '0);
    assign resp_err  = IMEM_RVALID && (discard == '0) && (outstanding == '0);

    assign fifo_pop    = INSTR_VALID && INSTR_READY;
    assign INSTR_VALID = (fifo_count != '0);
    assign {INSTR_PC, INSTR} = fifo_rdata;
    assign STATE       = state;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic accept_mis;

    // Misaligned PCs wait until nothing is in flight so the zero word stays in program order.
    assign misaligned = (PC[1:0] != 2'b00);
    assign accept_mis = can_accept && misaligned && (outstanding == '0);
    assign IMEM_REQ   = can_accept && !misaligned;
    assign PC_READY   = issue || accept_mis;
    assign fifo_push  = resp_keep || accept_mis;
    assign fifo_wdata = accept_mis ? {PC, {DATA_W{1'b0}}} : {tag_pc, IMEM_RDATA};

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            MISALIGN <= 1'b0;
        end else if (accept_mis) begin
            MISALIGN <= 1'b1;
        end
    end
`else
    assign IMEM_REQ   = can_accept;
    assign PC_READY   = issue;
    assign fifo_push  = resp_keep;
    assign fifo_wdata = {tag_pc, IMEM_RDATA};
`endif

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_tag_q (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (FLUSH),
        .push  (issue),
        .pop   (resp_keep),
        .wdata (PC),
        .rdata (tag_pc),
        .count (outstanding)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_instr_q (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (FLUSH),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    // A flush turns every in-flight fetch into a discard, minus one answered this cycle.
    always_comb begin
        discard_nxt = discard;
        if (FLUSH) begin
            discard_nxt = discard + outstanding - CNT_W'(resp_drop || resp_keep);
        end else if (resp_drop) begin
            discard_nxt = discard - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (FLUSH) begin
            state_nxt = (discard_nxt != '0) ? DRAIN : IDLE;
        end else begin
            case (state)
                IDLE:    if (PC_READY) state_nxt = BUSY;
                BUSY:    if ((outstanding == '0) && (fifo_count == '0) && !PC_READY) state_nxt = IDLE;
                DRAIN:   if (discard_nxt == '0) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            discard   <= '0;
            PROTO_ERR <= 1'b0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
            if (resp_err) begin
                PROTO_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stimulus pushes expected {pc, instr} pairs,
// a negedge monitor pops and compares every instruction handed to decode.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int W      = ADDR_W + DATA_W;

    // Clock and reset
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [ADDR_W-1:0] PC = '0;
    logic              PC_VALID = 1'b0;
    logic              PC_READY;
    logic              FLUSH = 1'b0;
    logic              IMEM_REQ;
    logic [ADDR_W-3:0] IMEM_ADDR;
    logic              IMEM_GNT = 1'b0;
    logic              IMEM_RVALID = 1'b0;
    logic [DATA_W-1:0] IMEM_RDATA = '0;
    logic              INSTR_VALID;
    logic              INSTR_READY = 1'b1;
    logic [DATA_W-1:0] INSTR;
    logic [ADDR_W-1:0] INSTR_PC;
    logic              PROTO_ERR;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              MISALIGN;
`endif
    fetch_state_t      STATE;

    instr_fetch_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PC          (PC),
        .PC_VALID    (PC_VALID),
        .PC_READY    (PC_READY),
        .FLUSH       (FLUSH),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .INSTR       (INSTR),
        .INSTR_PC    (INSTR_PC),
        .PROTO_ERR   (PROTO_ERR),
`ifdef FETCH_ALIGN_CHECK_EN
        .MISALIGN    (MISALIGN),
`endif
        .STATE       (STATE)
    );

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && INSTR_VALID && INSTR_READY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_instr: got pc=%h instr=%h, required no output", INSTR_PC, INSTR);
            end else begin
                check("instr_out", {INSTR_PC, INSTR}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_idle();
        PC_VALID    = 1'b0;
        FLUSH       = 1'b0;
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = '0;
    endtask

    task automatic drive_pc(input logic [ADDR_W-1:0] pc, input logic gnt);
        PC       = pc;
        PC_VALID = 1'b1;
        IMEM_GNT = gnt;
    endtask

    task automatic drive_resp(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] data,
                              input logic expect_out);
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = data;
        if (expect_out) exp_q.push_back({pc, data});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick();
        tick();
        RST = 1'b0;
        drive_idle();
        settle();
        check("rst_instr_valid", INSTR_VALID, 0);
        check("rst_proto_err", PROTO_ERR, 0);
        check("rst_state", 64'(STATE), 64'(IDLE));
        check("rst_imem_req", IMEM_REQ, 0);

        // Back-to-back fetch of 0x0 and 0x4
        tick(); drive_idle(); drive_pc(32'h0, 1'b1); settle();
        check("t1_req", IMEM_REQ, 1);
        check("t1_pc_ready", PC_READY, 1);
        tick(); drive_idle(); drive_pc(32'h4, 1'b1); drive_resp(32'h0, 32'h2408_0001, 1'b1); settle();
        check("t1_pc_ready2", PC_READY, 1);
        check("t1_addr", 64'(IMEM_ADDR), 64'h1);
        tick(); drive_idle(); drive_resp(32'h4, 32'h2409_0002, 1'b1); settle();
        check("t1_valid_first", INSTR_VALID, 1);
        tick(); drive_idle(); settle();
        check("t1_valid_second", INSTR_VALID, 1);
        tick(); drive_idle(); settle();
        check("t1_empty", INSTR_VALID, 0);
        tick(); settle();
        check("t1_idle", 64'(STATE), 64'(IDLE));

        // Credit exhaustion with decode stalled
        INSTR_READY = 1'b0;
        tick(); drive_idle(); drive_pc(32'h10, 1'b1);
        tick(); drive_idle(); drive_pc(32'h14, 1'b1); drive_resp(32'h10, 32'h8C08_0010, 1'b1);
        tick(); drive_idle(); drive_pc(32'h18, 1'b1); drive_resp(32'h14, 32'h8C09_0014, 1'b1); settle();
        check("t2_no_credit_ready", PC_READY, 0);
        check("t2_no_credit_req", IMEM_REQ, 0);
        tick(); drive_idle(); drive_pc(32'h18, 1'b1); settle();
        check("t2_full_hold", PC_READY, 0);
        tick(); drive_idle(); drive_pc(32'h18, 1'b1); INSTR_READY = 1'b1; settle();
        check("t2_pop_cycle", PC_READY, 0);
        tick(); drive_idle(); INSTR_READY = 1'b0; drive_pc(32'h18, 1'b1); settle();
        check("t2_issue_after_pop", PC_READY, 1);
        tick(); drive_idle(); drive_resp(32'h18, 32'h8C0A_0018, 1'b1);
        tick(); drive_idle(); INSTR_READY = 1'b1;
        tick(); drive_idle();
        tick(); drive_idle(); settle();
        check("t2_drained", INSTR_VALID, 0);

        // Flush with two fetches in flight
        tick(); drive_idle(); drive_pc(32'h20, 1'b1);
        tick(); drive_idle(); drive_pc(32'h24, 1'b1);
        tick(); drive_idle(); FLUSH = 1'b1; PC_VALID = 1'b1; IMEM_GNT = 1'b1; settle();
        check("t3_flush_no_req", IMEM_REQ, 0);
        tick(); drive_idle(); drive_pc(32'h100, 1'b1); drive_resp(32'h20, 32'hBAD0_0020, 1'b0); settle();
        check("t3_drain_state", 64'(STATE), 64'(DRAIN));
        check("t3_drain_no_req", IMEM_REQ, 0);
        check("t3_valid_after_flush", INSTR_VALID, 0);
        tick(); drive_idle(); drive_pc(32'h100, 1'b1); drive_resp(32'h24, 32'hBAD0_0024, 1'b0); settle();
        check("t3_drop_first", INSTR_VALID, 0);
        tick(); drive_idle(); drive_pc(32'h100, 1'b1); settle();
        check("t3_drop_second", INSTR_VALID, 0);
        check("t3_idle_again", 64'(STATE), 64'(IDLE));
        check("t3_reissue", PC_READY, 1);
        tick(); drive_idle(); drive_resp(32'h100, 32'h0800_0040, 1'b1);
        tick(); drive_idle();
        tick(); drive_idle(); settle();
        check("t3_empty", INSTR_VALID, 0);
        check("t3_no_proto_err", PROTO_ERR, 0);

        // Grant withheld for three cycles
        for (int i = 0; i < 3; i++) begin
            tick(); drive_idle(); drive_pc(32'h40, 1'b0); settle();
            check("t5_req_held", IMEM_REQ, 1);
            check("t5_no_accept", PC_READY, 0);
        end
        tick(); drive_idle(); drive_pc(32'h40, 1'b1); settle();
        check("t5_grant_accept", PC_READY, 1);
        tick(); drive_idle(); drive_resp(32'h40, 32'h1000_FFFF, 1'b1);
        tick(); drive_idle();
        tick(); drive_idle(); settle();
        check("t5_empty", INSTR_VALID, 0);

        // Reset while busy with a full buffer, then a stray response
        INSTR_READY = 1'b0;
        tick(); drive_idle(); drive_pc(32'h50, 1'b1);
        tick(); drive_idle(); drive_pc(32'h54, 1'b1); drive_resp(32'h50, 32'h1111_0050, 1'b0);
        tick(); drive_idle(); drive_resp(32'h54, 32'h1111_0054, 1'b0);
        tick(); drive_idle(); drive_pc(32'h58, 1'b1); settle();
        check("t4_full_valid", INSTR_VALID, 1);
        check("t4_busy", 64'(STATE), 64'(BUSY));
        check("t4_full_no_accept", PC_READY, 0);
        tick(); drive_idle(); RST = 1'b1; INSTR_READY = 1'b1;
        tick(); drive_idle(); RST = 1'b0; settle();
        check("t4_rst_valid", INSTR_VALID, 0);
        check("t4_rst_state", 64'(STATE), 64'(IDLE));
        check("t4_rst_proto", PROTO_ERR, 0);
        drive_resp(32'h0, 32'hDEAD_BEEF, 1'b0);
        tick(); drive_idle(); settle();
        check("t4_proto_set", PROTO_ERR, 1);
        check("t4_stray_dropped", INSTR_VALID, 0);
        tick(); settle();
        check("t4_proto_sticky", PROTO_ERR, 1);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC produces a zero instruction without a memory request
        tick(); drive_idle(); drive_pc(32'h2, 1'b1); settle();
        check("t6_no_req", IMEM_REQ, 0);
        check("t6_accept", PC_READY, 1);
        exp_q.push_back({32'h2, 32'h0});
        tick(); drive_idle(); settle();
        check("t6_misalign", MISALIGN, 1);
        tick(); drive_idle(); FLUSH = 1'b1;
        tick(); drive_idle(); settle();
        check("t6_misalign_clr", MISALIGN, 0);
`endif

        tick(); drive_idle(); settle();
        check("final_queue_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
